multicycle_ctrl: RTL

- Multicycle control sequencer that sits directly upstream of the LEGv8 datapath.
- Consumes the 11-bit opcode the datapath exports, latches its decoded class, and steps through FETCH/DECODE/EXEC/MEM/WB.
- Drives every datapath control input, plus PC/IR write enables and a handshake to a wait-stated data memory.
- Also counts retired instructions and traps illegal opcodes and memory timeouts.

---
 rtl/multicycle_ctrl.sv | 104 ++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer driving the LEGv8 datapath controls
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [10:0]      opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic             Reg2Loc,
  output logic             WRegLoc,
  output logic             ALUSrc,
  output logic             SregUp,
  output logic             MemRead,
  output logic             MemWrite,
  output logic [1:0]       ALUOp,
  output logic [2:0]       BranchOp,
  output logic [1:0]       MemtoReg,
  output logic [2:0]       state,
  output logic [1:0]       fault,
  output logic [CNT_W-1:0] retired
);
  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, HALT = 3'd7} state_t;
  typedef enum logic [3:0] {C_NOP, C_R, C_RS, C_I, C_LDUR, C_STUR, C_CBZ, C_CBNZ, C_BCOND, C_B, C_BL, C_MOVK, C_ILL} cls_t;
  state_t st;
  cls_t cls, dec;
  logic [TW-1:0] tmo;
  logic act, br, ld, sd;
  always_comb begin
    casez (opcode)
      11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000: dec = C_R;
      11'b10101011000, 11'b11101011000: dec = C_RS;
      11'b1?01000100?: dec = C_I;
      11'b11111000010: dec = C_LDUR;
      11'b11111000000: dec = C_STUR;
      11'b10110100???: dec = C_CBZ;
      11'b10110101???: dec = C_CBNZ;
      11'b01010100???: dec = C_BCOND;
      11'b000101?????: dec = C_B;
      11'b100101?????: dec = C_BL;
      11'b111100101??: dec = C_MOVK;
      default:         dec = C_ILL;
    endcase
  end
  assign state = st;
  assign act = st == EXEC || st == MEM || st == WB;
  assign br = cls inside {C_B, C_CBZ, C_CBNZ, C_BCOND};
  assign ld = cls == C_LDUR;
  assign sd = cls == C_STUR;
  assign IRWrite = st == FETCH;
  assign ALUOp = !act ? 2'b00 : (cls inside {C_R, C_RS}) ? 2'b10 : (cls inside {C_I, C_MOVK}) ? 2'b11 : (cls inside {C_CBZ, C_CBNZ}) ? 2'b01 : 2'b00;
  assign ALUSrc = act && (cls inside {C_I, C_LDUR, C_STUR, C_MOVK});
  assign Reg2Loc = act && (cls inside {C_STUR, C_CBZ, C_CBNZ, C_MOVK});
  assign SregUp = act && cls == C_RS;
  assign BranchOp = !act ? 3'd0 : cls == C_B ? 3'd1 : cls == C_CBZ ? 3'd2 : cls == C_CBNZ ? 3'd3 : cls == C_BCOND ? 3'd4 : cls == C_BL ? 3'd5 : 3'd0;
  assign MemRead = st == MEM && ld;
  assign MemWrite = st == MEM && sd;
  assign RegWrite = st == WB;
  assign WRegLoc = st == WB && cls == C_BL;
  assign MemtoReg = st != WB ? 2'b00 : ld ? 2'b01 : cls == C_BL ? 2'b10 : cls == C_MOVK ? 2'b11 : 2'b00;
  assign PCWrite = (st == EXEC && br) || (st == MEM && sd && mem_ready) || st == WB;
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= FETCH;
      cls <= C_NOP;
      fault <= 2'b00;
      retired <= '0;
      tmo <= '0;
    end else begin
      if (PCWrite) retired <= retired + CNT_W'(1);
      case (st)
        FETCH: st <= DECODE;
        DECODE: begin
          if (dec == C_ILL) begin
            fault <= 2'b01;
            st <= HALT;
          end else begin
            cls <= dec;
            st <= EXEC;
          end
        end
        EXEC: st <= (ld || sd) ? MEM : br ? FETCH : WB;
        MEM: begin
          if (mem_ready) begin
            tmo <= '0;
            st <= ld ? WB : FETCH;
          end else if (tmo == TW'(MEM_TIMEOUT - 1)) begin
            tmo <= '0;
            fault <= 2'b10;
            st <= HALT;
          end else begin
            tmo <= tmo + TW'(1);
          end
        end
        WB: st <= FETCH;
        default: st <= HALT;
      endcase
    end
  end
endmodule
